// File: rtl/rv32_exec_datapath_if.sv
// rv32_exec_datapath_if: core-FSM to execution-datapath bundle.
// master = core FSM side, slave = datapath side.
//   rs1/rs2/rd/wdata/we      register file read indices and write port
//   rdata1/rdata2            combinational register reads
//   funct3/funct7/fmt        instruction fields for the ALU-control decoder
//   alu_a/alu_b              ALU operands
//   alu_ctr/alu_result/zero  decoded op, registered result, zero flag
interface rv32_exec_datapath_if;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [3:0]  fmt;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_ctr;
    logic [31:0] alu_result;
    logic        zero;

    modport master (
        output rs1, rs2, rd, wdata, we,
        output funct3, funct7, fmt,
        output alu_a, alu_b,
        input  rdata1, rdata2,
        input  alu_ctr, alu_result, zero
    );

    modport slave (
        input  rs1, rs2, rd, wdata, we,
        input  funct3, funct7, fmt,
        input  alu_a, alu_b,
        output rdata1, rdata2,
        output alu_ctr, alu_result, zero
    );
endinterface

// File: rtl/rv32_exec_datapath.sv
// rv32_exec_datapath: RV32I register file, ALU-control decoder and
// one-cycle registered ALU for the multicycle core.
// Ports: clk, resetn (sync, active-low), bus (slave modport).
module rv32_exec_datapath (
    input logic                 clk,
    input logic                 resetn,
    rv32_exec_datapath_if.slave bus
);

    localparam logic [3:0] C_ADD   = 4'd0;
    localparam logic [3:0] C_SUB   = 4'd1;
    localparam logic [3:0] C_SLL   = 4'd2;
    localparam logic [3:0] C_SLT   = 4'd3;
    localparam logic [3:0] C_SLTU  = 4'd4;
    localparam logic [3:0] C_XOR   = 4'd5;
    localparam logic [3:0] C_SRL   = 4'd6;
    localparam logic [3:0] C_SRA   = 4'd7;
    localparam logic [3:0] C_OR    = 4'd8;
    localparam logic [3:0] C_AND   = 4'd9;
    localparam logic [3:0] C_PASSA = 4'd10;
    localparam logic [3:0] C_JALR  = 4'd11;

    logic [31:0] r_regs [32];
    logic [31:0] r_alu_result;
    logic [3:0]  w_alu_ctr;
    logic [31:0] w_alu_out;
    logic [4:0]  w_shamt;
    logic        w_is_r;

    // No write bypass: a same-cycle read sees the old contents.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= '0;
            end
            r_alu_result <= '0;
        end else begin
            if (bus.we && (bus.rd != 5'd0)) begin
                r_regs[bus.rd] <= bus.wdata;
            end
            r_alu_result <= w_alu_out;
        end
    end

    assign bus.rdata1 = (bus.rs1 == 5'd0) ? '0 : r_regs[bus.rs1];
    assign bus.rdata2 = (bus.rs2 == 5'd0) ? '0 : r_regs[bus.rs2];

    // funct7[5] selects SUB only for R-type; immediates carry
    // no funct7 there, but SRAI still uses it for funct3 5.
    assign w_is_r = (bus.fmt == 4'd0);

    always_comb begin
        w_alu_ctr = C_ADD;
        unique case (bus.fmt)
            4'd0, 4'd1: begin
                unique case (bus.funct3)
                    3'd0: w_alu_ctr = (w_is_r && bus.funct7[5])
                                      ? C_SUB : C_ADD;
                    3'd1: w_alu_ctr = C_SLL;
                    3'd2: w_alu_ctr = C_SLT;
                    3'd3: w_alu_ctr = C_SLTU;
                    3'd4: w_alu_ctr = C_XOR;
                    3'd5: w_alu_ctr = bus.funct7[5]
                                      ? C_SRA : C_SRL;
                    3'd6: w_alu_ctr = C_OR;
                    3'd7: w_alu_ctr = C_AND;
                endcase
            end
            4'd7:    w_alu_ctr = C_JALR;
            4'd8:    w_alu_ctr = C_PASSA;
            default: w_alu_ctr = C_ADD;
        endcase
    end

    assign w_shamt = bus.alu_b[4:0];

    always_comb begin
        w_alu_out = bus.alu_a + bus.alu_b;
        unique case (w_alu_ctr)
            C_SUB:   w_alu_out = bus.alu_a - bus.alu_b;
            C_SLL:   w_alu_out = bus.alu_a << w_shamt;
            C_SLT:   w_alu_out = {31'd0, $signed(bus.alu_a)
                                          < $signed(bus.alu_b)};
            C_SLTU:  w_alu_out = {31'd0, bus.alu_a < bus.alu_b};
            C_XOR:   w_alu_out = bus.alu_a ^ bus.alu_b;
            C_SRL:   w_alu_out = bus.alu_a >> w_shamt;
            C_SRA:   w_alu_out = $signed(bus.alu_a) >>> w_shamt;
            C_OR:    w_alu_out = bus.alu_a | bus.alu_b;
            C_AND:   w_alu_out = bus.alu_a & bus.alu_b;
            C_PASSA: w_alu_out = bus.alu_a;
            C_JALR:  w_alu_out = (bus.alu_a + bus.alu_b)
                                 & 32'hFFFF_FFFE;
            default: w_alu_out = bus.alu_a + bus.alu_b;
        endcase
    end

    assign bus.alu_ctr    = w_alu_ctr;
    assign bus.alu_result = r_alu_result;
    assign bus.zero       = (r_alu_result == 32'd0);

endmodule

// File: tb/tb_rv32_exec_datapath.sv
// tb_rv32_exec_datapath: directed and randomized checks of the
// execution datapath against a behavioural model.
module tb_rv32_exec_datapath;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    rv32_exec_datapath_if dp_if ();

    rv32_exec_datapath dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (dp_if)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] m_regs [32];
    logic [31:0] m_alu;

    typedef struct {
        logic [3:0]  fmt;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Operation named by the instruction fields, as a control code.
    function automatic logic [3:0] ref_ctr(input logic [3:0] fmt,
                                           input logic [2:0] f3,
                                           input logic [6:0] f7);
        if (fmt == 4'd7) return 4'd11;
        if (fmt == 4'd8) return 4'd10;
        if (fmt > 4'd1) return 4'd0;
        case (f3)
            3'd0: return (fmt == 4'd0 && f7[5]) ? 4'd1 : 4'd0;
            3'd1: return 4'd2;
            3'd2: return 4'd3;
            3'd3: return 4'd4;
            3'd4: return 4'd5;
            3'd5: return f7[5] ? 4'd7 : 4'd6;
            3'd6: return 4'd8;
            default: return 4'd9;
        endcase
    endfunction

    function automatic logic [31:0] ref_exec(input logic [3:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
        int unsigned sh;
        logic [63:0] ext;
        longint sa;
        longint sb;
        sh  = int'(b[4:0]);
        ext = {{32{a[31]}}, a} >> sh;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        case (op)
            4'd1:  return a - b;
            4'd2:  return a << sh;
            4'd3:  return (sa < sb) ? 32'd1 : 32'd0;
            4'd4:  return ({1'b0, a} < {1'b0, b}) ? 32'd1 : 32'd0;
            4'd5:  return a ^ b;
            4'd6:  return a >> sh;
            4'd7:  return ext[31:0];
            4'd8:  return a | b;
            4'd9:  return a & b;
            4'd10: return a;
            4'd11: return (a + b) & ~32'd1;
            default: return a + b;
        endcase
    endfunction

    task automatic set_alu(input logic [3:0] fmt, input logic [2:0] f3,
                           input logic [6:0] f7, input logic [31:0] a,
                           input logic [31:0] b);
        dp_if.fmt    = fmt;
        dp_if.funct3 = f3;
        dp_if.funct7 = f7;
        dp_if.alu_a  = a;
        dp_if.alu_b  = b;
    endtask

    // Advance one edge, updating the model from the sampled inputs.
    task automatic tick();
        @(posedge clk);
        if (!resetn) begin
            for (int i = 0; i < 32; i++) m_regs[i] = '0;
            m_alu = '0;
        end else begin
            if (dp_if.we && dp_if.rd != 5'd0)
                m_regs[dp_if.rd] = dp_if.wdata;
            m_alu = ref_exec(ref_ctr(dp_if.fmt, dp_if.funct3,
                                     dp_if.funct7),
                             dp_if.alu_a, dp_if.alu_b);
        end
        #1;
    endtask

    initial begin
        vecs[0]  = '{4'd0, 3'd0, 7'h20, 32'd5, 32'd7, 32'hFFFFFFFE};
        vecs[1]  = '{4'd0, 3'd5, 7'h20, 32'h80000000, 32'd4,
                     32'hF8000000};
        vecs[2]  = '{4'd0, 3'd5, 7'h00, 32'h80000000, 32'd4,
                     32'h08000000};
        vecs[3]  = '{4'd1, 3'd0, 7'h20, 32'd1, 32'hFFFFFFFF, 32'd0};
        vecs[4]  = '{4'd0, 3'd2, 7'h00, 32'hFFFFFFFF, 32'd1, 32'd1};
        vecs[5]  = '{4'd0, 3'd3, 7'h00, 32'hFFFFFFFF, 32'd1, 32'd0};
        vecs[6]  = '{4'd8, 3'd0, 7'h00, 32'hABCDE000, 32'd0,
                     32'hABCDE000};
        vecs[7]  = '{4'd7, 3'd0, 7'h00, 32'h101, 32'd4, 32'h104};
        vecs[8]  = '{4'd5, 3'd0, 7'h00, 32'h100, 32'hFFFFFFF8,
                     32'hF8};
        vecs[9]  = '{4'd1, 3'd5, 7'h20, 32'h80000000, 32'd4,
                     32'hF8000000};
        vecs[10] = '{4'd1, 3'd1, 7'h20, 32'd1, 32'd4, 32'h10};

        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_alu = '0;

        // Reset overrides a write request in the same cycle.
        resetn = 1'b0;
        dp_if.rs1 = 5'd3; dp_if.rs2 = 5'd5;
        dp_if.rd = 5'd3; dp_if.wdata = 32'hCAFEF00D;
        dp_if.we = 1'b1;
        set_alu(4'd0, 3'd0, 7'd0, 32'd9, 32'd9);
        tick();
        resetn = 1'b1;
        dp_if.we = 1'b0;
        #1;
        chk("rst_rdata1", dp_if.rdata1, 32'd0);
        chk("rst_rdata2", dp_if.rdata2, 32'd0);
        chk("rst_alu", dp_if.alu_result, 32'd0);
        chk("rst_zero", {31'd0, dp_if.zero}, 32'd1);

        // Writes to x0 are discarded.
        dp_if.rd = 5'd0; dp_if.wdata = 32'hDEADBEEF;
        dp_if.we = 1'b1; dp_if.rs1 = 5'd0;
        tick();
        dp_if.we = 1'b0;
        #1;
        chk("x0_read", dp_if.rdata1, 32'd0);

        // No bypass: old value until the edge, new value after it.
        dp_if.rs1 = 5'd5; dp_if.rd = 5'd5;
        dp_if.wdata = 32'h12345678; dp_if.we = 1'b1;
        #1;
        chk("wr_before", dp_if.rdata1, 32'd0);
        tick();
        dp_if.we = 1'b0;
        #1;
        chk("wr_after", dp_if.rdata1, 32'h12345678);
        chk("wr_model", dp_if.rdata1, m_regs[5]);

        // Directed decoder/ALU vectors.
        foreach (vecs[i]) begin
            set_alu(vecs[i].fmt, vecs[i].f3, vecs[i].f7,
                    vecs[i].a, vecs[i].b);
            #1;
            chk($sformatf("dir_ctr%0d", i), {28'd0, dp_if.alu_ctr},
                {28'd0, ref_ctr(vecs[i].fmt, vecs[i].f3,
                                vecs[i].f7)});
            tick();
            chk($sformatf("dir_res%0d", i), dp_if.alu_result,
                vecs[i].exp);
            chk($sformatf("dir_zero%0d", i), {31'd0, dp_if.zero},
                {31'd0, vecs[i].exp == 32'd0});
        end

        // Random traffic: operands change every cycle.
        for (int n = 0; n < 400; n++) begin
            set_alu(4'($urandom_range(0, 15)), 3'($urandom),
                    7'($urandom), $urandom,
                    ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom);
            if (n % 13 == 0) dp_if.alu_b = dp_if.alu_a;
            dp_if.rs1   = 5'($urandom);
            dp_if.rs2   = 5'($urandom);
            dp_if.rd    = 5'($urandom);
            dp_if.wdata = $urandom;
            dp_if.we    = 1'($urandom);
            #1;
            chk("rnd_rdata1", dp_if.rdata1, m_regs[dp_if.rs1]);
            chk("rnd_rdata2", dp_if.rdata2, m_regs[dp_if.rs2]);
            chk("rnd_ctr", {28'd0, dp_if.alu_ctr},
                {28'd0, ref_ctr(dp_if.fmt, dp_if.funct3,
                                dp_if.funct7)});
            tick();
            chk("rnd_alu", dp_if.alu_result, m_alu);
            chk("rnd_zero", {31'd0, dp_if.zero},
                {31'd0, m_alu == 32'd0});
        end

        // Reset mid-sequence drops the pending write and clears all.
        dp_if.rd = 5'd7; dp_if.wdata = 32'h77777777;
        dp_if.we = 1'b1;
        set_alu(4'd0, 3'd0, 7'd0, 32'd1, 32'd2);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        dp_if.we = 1'b0;
        #1;
        chk("mid_rst_alu", dp_if.alu_result, 32'd0);
        chk("mid_rst_zero", {31'd0, dp_if.zero}, 32'd1);
        for (int i = 0; i < 32; i++) begin
            dp_if.rs1 = 5'(i);
            dp_if.rs2 = 5'(31 - i);
            #1;
            chk("mid_rst_rd1", dp_if.rdata1, 32'd0);
            chk("mid_rst_rd2", dp_if.rdata2, 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rv32_exec_datapath.md
# rv32_exec_datapath

RV32I execution datapath for the multicycle core: a 32×32 register file, an ALU-control decoder and a one-cycle registered ALU. The core FSM drives operand selection, register indices and write enables. The block performs register reads and writes, translates instruction fields into an ALU operation, and delivers the ALU result one clock later. It holds no FSM of its own.

## Interface
- No parameters; data width 32, 32 architectural registers.
- Reset: `resetn`, synchronous, active-low. Clock: `clk`.
- clk  in  1  rising-edge clock for register writes and the ALU result register
- resetn  in  1  synchronous active-low reset
- rs1  in  5  read index, port 1
- rs2  in  5  read index, port 2
- rd  in  5  write index
- wdata  in  32  write data
- we  in  1  register write enable
- rdata1  out  32  register[rs1], combinational
- rdata2  out  32  register[rs2], combinational
- funct3  in  3  instruction bits [14:12]
- funct7  in  7  instruction bits [31:25]
- fmt  in  4  format code: 0 R, 1 I, 2 I-load, 3 I-env, 4 S, 5 B, 6 JAL, 7 JALR, 8 LUI, 9 AUIPC
- alu_a  in  32  ALU operand A
- alu_b  in  32  ALU operand B
- alu_ctr  out  4  decoded ALU operation, combinational
- alu_result  out  32  registered ALU result
- zero  out  1  high when alu_result == 0

## Operation
- **Register file**
  - Reads are asynchronous.
  - Register x0 always reads 0. Writes to x0 are discarded.
  - Writes occur at the rising edge when we=1.
- **ALU control codes**
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT (signed), 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSA, 11 JALR-ADD (a+b with bit0 cleared).
  - Codes 12–15 behave as ADD.
- **Decoder, fmt 0 (R)**
  - funct3 0 → SUB if funct7[5] else ADD.
  - funct3 1 → SLL; 2 → SLT; 3 → SLTU; 4 → XOR.
  - funct3 5 → SRA if funct7[5] else SRL.
  - funct3 6 → OR; 7 → AND.
- **Decoder, fmt 1 (I)**
  - Same mapping as fmt 0, except funct3 0 is always ADD (funct7 ignored).
  - funct7[5] is honoured only for funct3 5.
- **Decoder, other formats**
  - fmt 2, 4, 5, 6, 9 → ADD.
  - fmt 7 → JALR-ADD.
  - fmt 8 → PASSA.
  - fmt 3 and 10–15 → ADD.
- **Arithmetic**
  - Results are modulo 2^32.
  - Shift amount is alu_b[4:0].
  - SLT and SLTU return 32'd1 or 32'd0.

## Timing
- alu_result is latched at every rising edge from (alu_a, alu_b, alu_ctr) of that cycle, with no enable. Latency is exactly one cycle.
- zero is derived combinationally from alu_result.
- Write followed by read:
  - A same-cycle read of the register being written returns the old value (no bypass).
  - The new value is visible after the edge.
- Reset (resetn=0 at a rising edge):
  - All 32 registers clear to 0.
  - alu_result clears to 0, so zero=1.
  - Reset overrides we.
- Reset asserted mid-sequence discards any pending write in that cycle.
- Outputs after reset: rdata1=rdata2=0, alu_result=0, zero=1; alu_ctr follows its inputs.

## Test plan
- **Reset and x0:** reset 1 cycle; write x0=0xDEADBEEF → rdata1 with rs1=0 reads 0. After reset, rdata with rs1=5 reads 0 and zero=1.
- **Write/read ordering:** write x5=0x12345678 with rs1=5 in the same cycle → rdata1 stays 0 until the edge, then reads 0x12345678.
- **R-type SUB/SRA:**
  - fmt0, f3=0, f7=0x20, a=5, b=7 → next cycle alu_result=0xFFFFFFFE.
  - f3=5, f7=0x20, a=0x80000000, b=4 → 0xF8000000.
  - f7=0 with the same operands → SRL gives 0x08000000.
- **I-type and compares:**
  - fmt1, f3=0, f7=0x20, a=1, b=0xFFFFFFFF → 0 and zero=1.
  - SLT, a=0xFFFFFFFF, b=1 → 1.
  - SLTU with the same operands → 0.
- **Address formats:**
  - fmt8, a=0xABCDE000 → 0xABCDE000.
  - fmt7, a=0x101, b=4 → 0x104.
  - fmt5, a=0x100, b=0xFFFFFFF8 → 0xF8.
- **Latency:** change operands every cycle → alu_result always reflects the previous cycle's inputs.
